key_sched_buffer: RTL and testbench
===================================

KEY_SCHED_BUFFER -- requirements
Module: key_sched_buffer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port key_valid, input, 1, cipher key offered on key_in.
REQ-004 SHALL have port key_in, input, [0:127], cipher key, bit 0 = MSB of byte 0.
REQ-005 SHALL have port key_ready, output, 1, key accepted on an edge where key_valid and key_ready are both 1.
REQ-006 SHALL have port busy, output, 1, expansion in progress.
REQ-007 SHALL have port keys_done, output, 1, all 11 round keys stored and readable.
REQ-008 SHALL have port rd_en, input, 1, read request.
REQ-009 SHALL have port rd_round, input, [3:0], logical round number 0..10.
REQ-010 SHALL have port rd_inv, input, 1; 0 = forward order (entry rd_round), 1 = decryption order (entry 10-rd_round).
REQ-011 SHALL have port rd_key, output, [0:127], registered round key.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_key.
REQ-013 SHALL have port rd_err, output, 1, one-cycle pulse for a rejected read.

Function
REQ-014 SHALL implement FSM IDLE -> EXPAND -> READY; key acceptance in IDLE or READY moves to EXPAND.
REQ-015 SHALL hold key_ready=1 in IDLE and READY, 0 in EXPAND; busy=1 only in EXPAND; keys_done=1 only in READY.
REQ-016 SHALL write key_in to entry 0 on the accepting edge (E0) and load rcon=8'h01.
REQ-017 SHALL compute entry n (n=1..10) on edge En from entry n-1: RotWord of last word, AES S-box SubWord, XOR with rcon in the top byte, cumulative XOR across the four words.
REQ-018 SHALL advance rcon each EXPAND edge by GF(2^8) xtime (poly 0x11B), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-019 SHALL enter READY on E10; keys_done is visible in the cycle after E10, 10 cycles after acceptance.
REQ-020 SHALL ignore key_valid during EXPAND; no restart, no error.
REQ-021 SHALL serve a read accepted in READY with rd_round<=10 by registering the selected entry into rd_key, pulsing rd_valid the next cycle; 1-cycle latency, one read per cycle.
REQ-022 SHALL reject rd_en when not in READY or when rd_round>10: pulse rd_err next cycle, rd_valid=0, rd_key unchanged.
REQ-023 SHALL, when key_valid and rd_en coincide in READY, serve the read from pre-update contents and then enter EXPAND.
REQ-024 SHALL hold rd_key between reads.

Reset
REQ-025 SHALL, on rst=1 at an edge, enter IDLE with key_ready=1, busy=0, keys_done=0, rd_valid=0, rd_err=0, rd_key=0, rcon=8'h01.
REQ-026 SHALL abort an in-progress expansion on reset; key buffer contents are not cleared and are unreadable until the next keys_done.
REQ-027 SHALL give rst priority over key_valid and rd_en in the same cycle.

Configuration
REQ-028 SHALL recognise macro KSB_EQ_INV_CIPHER_EN.
REQ-029 SHALL, with KSB_EQ_INV_CIPHER_EN defined, apply InvMixColumns to the selected key before registering it when rd_inv=1 and stored entry is 1..9; entries 0 and 10 pass unchanged; latency stays 1 cycle.
REQ-030 SHALL, without the macro, return raw stored keys for both rd_inv values, with no InvMixColumns logic synthesised.

Verification
REQ-031 SHALL test: key 2b7e151628aed2a6abf7158809cf4f3c accepted -> keys_done 10 cycles later; rd_round=1, rd_inv=0 -> rd_key a0fafe1788542cb123a339392a6c7605, rd_valid next cycle.
REQ-032 SHALL test: same key, rd_round=0, rd_inv=1 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=10, rd_inv=1 -> 2b7e1516...4f3c.
REQ-033 SHALL test: rd_round=11 in READY, and any rd_en during EXPAND -> rd_err pulse, rd_valid=0, rd_key unchanged.
REQ-034 SHALL test: rst asserted at E5 of expansion -> IDLE next cycle, keys_done=0, key_ready=1; reloading the key gives correct keys.
REQ-035 SHALL test: key_valid plus rd_en (round 0) in READY -> old key0 returned, busy=1, new key expanded correctly; key_valid mid-EXPAND ignored.
REQ-036 SHALL test with KSB_EQ_INV_CIPHER_EN: rd_inv=1, rd_round=1 -> InvMixColumns(round-9 key) versus software reference; rd_round=0 -> raw round-10 key.

Source files
------------

// File: rtl/key_sched_buffer.sv
// key_sched_buffer: AES-128 key expansion with an 11-entry round-key buffer.
// A key accepted in IDLE/READY is expanded one round key per cycle (10 cycles)
// into the buffer; afterwards any round key can be read back with one cycle of
// latency, in forward or decryption order.
// Optional build macro: KSB_EQ_INV_CIPHER_EN -- when defined, decryption-order
// reads of middle entries (1..9) return InvMixColumns(key) for the equivalent
// inverse cipher; entries 0 and 10 are always returned raw.
module key_sched_buffer (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [0:127] key_in,
   output logic         key_ready,
   output logic         busy,
   output logic         keys_done,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   input  logic         rd_inv,
   output logic [0:127] rd_key,
   output logic         rd_valid,
   output logic         rd_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;

   // AES forward S-box, byte x lives at bits [8x +: 8]
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{x, 3'b000} +: 8];
   endfunction

   // GF(2^8) multiply by 2, reduction polynomial 0x11B
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef KSB_EQ_INV_CIPHER_EN
   // InvMixColumns over the four 32-bit columns of a round key
   function automatic logic [127:0] inv_mix(input logic [127:0] k);
      logic [127:0] r;
      logic [7:0]   a [0:3];
      logic [7:0]   m9 [0:3];
      logic [7:0]   mb [0:3];
      logic [7:0]   md [0:3];
      logic [7:0]   me [0:3];
      logic [7:0]   x2, x4, x8;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) begin
            a[j]  = k[127 - 32*c - 8*j -: 8];
            x2    = xt(a[j]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
         end
         r[127 - 32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         r[119 - 32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         r[111 - 32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         r[103 - 32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return r;
   endfunction
`endif

   logic [1:0]   state_reg;
   logic [3:0]   cnt_reg;
   logic [7:0]   rcon_reg;
   logic [0:127] work_reg;
   logic [0:127] key_mem [0:10];

   logic         accept;
   logic [0:127] next_key;
   logic         mem_we;
   logic [3:0]   mem_waddr;
   logic [0:127] mem_wdata;
   logic         rd_ok;
   logic [3:0]   rd_addr;
   logic [0:127] rd_data;

   assign key_ready = (state_reg == ST_IDLE) || (state_reg == ST_READY);
   assign busy      = (state_reg == ST_EXPAND);
   assign keys_done = (state_reg == ST_READY);
   assign accept    = key_valid && key_ready;

   // Next round key from the previous one (RotWord, SubWord, rcon, XOR chain)
   always_comb begin
      logic [31:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
      w0  = work_reg[0  +: 32];
      w1  = work_reg[32 +: 32];
      w2  = work_reg[64 +: 32];
      w3  = work_reg[96 +: 32];
      rot = {w3[23:0], w3[31:24]};
      tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon_reg, 24'h000000};
      n0  = w0 ^ tmp;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // Buffer write port: raw key on acceptance, computed key each expand cycle
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = 4'd0;
      mem_wdata = key_in;
      if (!rst) begin
         if (state_reg == ST_EXPAND) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_reg;
            mem_wdata = next_key;
         end else if (accept) begin
            mem_we    = 1'b1;
         end
      end
   end

   // Control FSM, round counter, rcon and the working copy of the last key
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         rcon_reg  <= 8'h01;
         work_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_READY: begin
               if (accept) begin
                  state_reg <= ST_EXPAND;
                  cnt_reg   <= 4'd1;
                  rcon_reg  <= 8'h01;
                  work_reg  <= key_in;
               end
            end
            ST_EXPAND: begin
               work_reg <= next_key;
               rcon_reg <= xt(rcon_reg);
               cnt_reg  <= cnt_reg + 4'd1;
               if (cnt_reg == 4'd10)
                  state_reg <= ST_READY;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Round-key buffer storage (contents survive reset)
   always_ff @(posedge clk) begin
      if (mem_we)
         key_mem[mem_waddr] <= mem_wdata;
   end

   // Read address: decryption order mirrors the round number
   always_comb begin
      rd_ok   = rd_en && keys_done && (rd_round <= 4'd10);
      rd_addr = rd_inv ? (4'd10 - rd_round) : rd_round;
      if (rd_addr > 4'd10)
         rd_addr = 4'd0;
      rd_data = key_mem[rd_addr];
`ifdef KSB_EQ_INV_CIPHER_EN
      if (rd_inv && (rd_addr != 4'd0) && (rd_addr != 4'd10))
         rd_data = inv_mix(key_mem[rd_addr]);
`endif
   end

   // Registered read result and its qualifying pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_key   <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         rd_err   <= rd_en && !rd_ok;
         if (rd_ok)
            rd_key <= rd_data;
      end
   end

endmodule

// File: tb/tb_key_sched_buffer.sv
// Directed testbench for key_sched_buffer using FIPS-197 and all-zero key schedules.
module tb_key_sched_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [0:127] key_in;
   logic         key_ready;
   logic         busy;
   logic         keys_done;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic         rd_inv;
   logic [0:127] rd_key;
   logic         rd_valid;
   logic         rd_err;

   int total = 0;
   int bad   = 0;
   logic [127:0] last_key;

   logic [127:0] ka [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   logic [127:0] kz [0:10] = '{
      128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e};

   key_sched_buffer dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
      .key_ready(key_ready), .busy(busy), .keys_done(keys_done),
      .rd_en(rd_en), .rd_round(rd_round), .rd_inv(rd_inv),
      .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef KSB_EQ_INV_CIPHER_EN
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_imc(input logic [127:0] k);
      logic [127:0] r = '0;
      logic [7:0] c0, c1, c2, c3;
      for (int c = 0; c < 4; c++) begin
         c0 = k[127 - 32*c -: 8];
         c1 = k[119 - 32*c -: 8];
         c2 = k[111 - 32*c -: 8];
         c3 = k[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
         r[119 - 32*c -: 8] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
         r[111 - 32*c -: 8] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
         r[103 - 32*c -: 8] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
      end
      return r;
   endfunction
`endif

   // Good read: one-cycle latency, rd_valid pulse, expected key
   task automatic do_read(input string tag, input logic [3:0] rnd, input logic inv,
                          input logic [127:0] exp);
      rd_en = 1'b1; rd_round = rnd; rd_inv = inv;
      tick();
      rd_en = 1'b0;
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_err"}, rd_err, 0);
      check({tag, "_key"}, rd_key, exp);
      last_key = exp;
   endtask

   // Rejected read: rd_err pulse, no rd_valid, rd_key untouched
   task automatic bad_read(input string tag, input logic [3:0] rnd);
      rd_en = 1'b1; rd_round = rnd; rd_inv = 1'b0;
      tick();
      rd_en = 1'b0;
      check({tag, "_err"}, rd_err, 1);
      check({tag, "_valid"}, rd_valid, 0);
      check({tag, "_key"}, rd_key, last_key);
   endtask

   // Count cycles until keys_done, bounded
   task automatic wait_done(input int start, output int n);
      n = start;
      while (!keys_done && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      logic [127:0] exp9;
      rst = 1'b1; key_valid = 1'b0; key_in = '0;
      rd_en = 1'b0; rd_round = 4'd0; rd_inv = 1'b0;
      last_key = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_key_ready", key_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_keys_done", keys_done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_rd_key", rd_key, 0);

      bad_read("idle_read", 4'd0);

      // FIPS-197 key, with a rejected read during expansion
      key_valid = 1'b1; key_in = ka[0];
      tick();
      key_valid = 1'b0;
      check("exp_busy", busy, 1);
      check("exp_key_ready", key_ready, 0);
      rd_en = 1'b1; rd_round = 4'd2; rd_inv = 1'b0;
      tick();
      rd_en = 1'b0;
      check("exp_read_err", rd_err, 1);
      check("exp_read_valid", rd_valid, 0);
      check("exp_read_key", rd_key, last_key);
      wait_done(1, n);
      check("done_latency", n, 10);
      check("ready_key_ready", key_ready, 1);

      do_read("a_r1", 4'd1, 1'b0, ka[1]);
      do_read("a_inv_r0", 4'd0, 1'b1, ka[10]);
      do_read("a_inv_r10", 4'd10, 1'b1, ka[0]);
      do_read("a_r5", 4'd5, 1'b0, ka[5]);
      tick(); tick();
      check("hold_key", rd_key, last_key);
      check("hold_valid", rd_valid, 0);
      bad_read("round11", 4'd11);

`ifdef KSB_EQ_INV_CIPHER_EN
      exp9 = ref_imc(ka[9]);
`else
      exp9 = ka[9];
`endif
      do_read("a_inv_r1", 4'd1, 1'b1, exp9);

      // Reset at E5 of a new expansion
      key_valid = 1'b1; key_in = ka[0];
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_key = '0;
      check("abort_keys_done", keys_done, 0);
      check("abort_key_ready", key_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_rd_key", rd_key, 0);
      bad_read("abort_read", 4'd1);
      key_valid = 1'b1; key_in = ka[0];
      tick();
      key_valid = 1'b0;
      wait_done(0, n);
      check("reload_latency", n, 10);
      do_read("reload_r3", 4'd3, 1'b0, ka[3]);
      do_read("reload_r10", 4'd10, 1'b0, ka[10]);

      // Key load coinciding with a read: old key0 returned, then zero key expands
      key_valid = 1'b1; key_in = '0;
      rd_en = 1'b1; rd_round = 4'd0; rd_inv = 1'b0;
      tick();
      key_valid = 1'b0; rd_en = 1'b0;
      check("coinc_valid", rd_valid, 1);
      check("coinc_key", rd_key, ka[0]);
      check("coinc_busy", busy, 1);
      last_key = ka[0];
      key_valid = 1'b1; key_in = ka[0];
      tick();
      key_valid = 1'b0;
      check("ignored_busy", busy, 1);
      wait_done(1, n);
      check("zero_latency", n, 10);
      do_read("z_r0", 4'd0, 1'b0, kz[0]);
      do_read("z_r1", 4'd1, 1'b0, kz[1]);
      do_read("z_r9", 4'd9, 1'b0, kz[9]);
      do_read("z_inv_r0", 4'd0, 1'b1, kz[10]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
